// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode constants, HALT word and fetch FSM states.
package cpu_pkg;

  localparam int unsigned PC_W    = 10;
  localparam int unsigned INSTR_W = 9;
  localparam int unsigned CNT_W   = 16;

  localparam logic [2:0] OP_RXOR    = 3'b000;
  localparam logic [2:0] OP_SHIFT   = 3'b001;
  localparam logic [2:0] OP_MEM     = 3'b010;
  localparam logic [2:0] OP_BNEQ    = 3'b011;
  localparam logic [2:0] OP_HALFSET = 3'b100;
  localparam logic [2:0] OP_AND     = 3'b101;
  localparam logic [2:0] OP_BLT     = 3'b110;
  localparam logic [2:0] OP_NOP     = 3'b111;

  localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Bus between the fetch stage and its surroundings (run control, ROM, decoder, branch resolution).
interface instr_fetch_if;
  import cpu_pkg::*;

  logic               Start;
  logic               Done;
  logic [PC_W-1:0]    InstrAddr;
  logic [INSTR_W-1:0] InstrIn;
  logic [2:0]         Instr;
  logic [2:0]         TypeSelect;
  logic [5:0]         Operand;
  logic               Valid;
  logic               Branch;
  logic               BranchTaken;
  logic [PC_W-1:0]    Target;
  logic [CNT_W-1:0]   CycleCount;

  modport master (
    input  Start, InstrIn, Branch, BranchTaken, Target,
    output Done, InstrAddr, Instr, TypeSelect, Operand, Valid, CycleCount
  );

  modport slave (
    output Start, InstrIn, Branch, BranchTaken, Target,
    input  Done, InstrAddr, Instr, TypeSelect, Operand, Valid, CycleCount
  );

endinterface

// File: rtl/prog_counter.sv
// Program counter register: clear beats load beats increment; otherwise hold.
module prog_counter
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (clr) begin
      pc_d = '0;
    end else if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + PC_W'(1);  // wraps silently at the top of the address space
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: IDLE/RUN/DONE run control, PC sequencing with absolute branches, decoder field gating.
// Optional cycle counter compiled in with FETCH_CYCLE_CNT_EN.
module instr_fetch
  import cpu_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset_n,
  instr_fetch_if.master bus
);

  fetch_state_t    state_q;
  fetch_state_t    state_d;
  logic            done_q;
  logic            done_d;
  logic            pc_clr;
  logic            pc_load;
  logic            pc_inc;
  logic [PC_W-1:0] pc;
  logic            run;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // HALT wins over a taken branch; Start only matters outside RUN.
  always_comb begin
    state_d = state_q;
    pc_clr  = 1'b0;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.Start) begin
          state_d = RUN;
          pc_clr  = 1'b1;
        end
      end
      RUN: begin
        if (bus.InstrIn == HALT_INSTR) begin
          state_d = DONE;
        end else if (bus.Branch && bus.BranchTaken) begin
          pc_load = 1'b1;
        end else begin
          pc_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
  end

  prog_counter u_pc (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .clr      (pc_clr),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (bus.Target),
    .pc       (pc)
  );

  assign run            = (state_q == RUN);
  assign bus.InstrAddr  = pc;
  assign bus.Done       = done_q;
  assign bus.Valid      = run;
  assign bus.Instr      = run ? bus.InstrIn[8:6] : OP_NOP;
  assign bus.TypeSelect = run ? bus.InstrIn[2:0] : 3'b000;
  assign bus.Operand    = run ? bus.InstrIn[5:0] : 6'b000000;

`ifdef FETCH_CYCLE_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Cleared on the start edge, counts every RUN cycle including HALT, saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (!run && bus.Start) begin
      cnt_d = '0;
    end else if (run && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.CycleCount = cnt_q;
`else
  assign bus.CycleCount = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: run/halt, restart, branches, wrap, HALT-vs-branch, async reset.
module tb_instr_fetch;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [INSTR_W-1:0] rom [0:(1<<PC_W)-1];

  instr_fetch_if bus ();

  instr_fetch dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.InstrIn = rom[bus.InstrAddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
`ifdef FETCH_CYCLE_CNT_EN
    return 32'(n);
`else
    return 32'(n) & 32'h0;
`endif
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < (1 << PC_W); i++) rom[i] = 9'h000;
    rom[0] = 9'h040;
    rom[1] = 9'h080;
    rom[2] = 9'h1FF;
    rst_n           = 1'b0;
    bus.Start       = 1'b0;
    bus.Branch      = 1'b0;
    bus.BranchTaken = 1'b0;
    bus.Target      = '0;

    #12;
    chk("rst_done",  32'(bus.Done), 32'd0);
    chk("rst_addr",  32'(bus.InstrAddr), 32'd0);
    chk("rst_instr", 32'(bus.Instr), 32'd7);
    chk("rst_valid", 32'(bus.Valid), 32'd0);
    chk("rst_opnd",  32'(bus.Operand), 32'd0);
    chk("rst_tsel",  32'(bus.TypeSelect), 32'd0);
    chk("rst_cnt",   32'(bus.CycleCount), 32'd0);
    rst_n = 1'b1;

    // Idle without Start stays idle
    tick();
    chk("idle_valid", 32'(bus.Valid), 32'd0);

    // Program 0x040, 0x080, HALT
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    chk("p0_addr",  32'(bus.InstrAddr), 32'd0);
    chk("p0_instr", 32'(bus.Instr), 32'd1);
    chk("p0_valid", 32'(bus.Valid), 32'd1);
    tick();
    chk("p1_addr",  32'(bus.InstrAddr), 32'd1);
    chk("p1_instr", 32'(bus.Instr), 32'd2);
    chk("p1_done",  32'(bus.Done), 32'd0);
    tick();
    chk("p2_addr",  32'(bus.InstrAddr), 32'd2);
    chk("p2_instr", 32'(bus.Instr), 32'd7);
    chk("p2_valid", 32'(bus.Valid), 32'd1);
    tick();
    chk("h_done",  32'(bus.Done), 32'd1);
    chk("h_addr",  32'(bus.InstrAddr), 32'd2);
    chk("h_valid", 32'(bus.Valid), 32'd0);
    chk("h_instr", 32'(bus.Instr), 32'd7);
    chk("h_cnt",   32'(bus.CycleCount), cnt_exp(3));
    tick();
    chk("h_hold_done", 32'(bus.Done), 32'd1);
    chk("h_hold_addr", 32'(bus.InstrAddr), 32'd2);

    // Restart from DONE; Start held through first RUN cycle is ignored
    rom[2] = 9'h000;
    rom[3] = 9'h0AB;
    bus.Start = 1'b1;
    tick();
    chk("rs_addr", 32'(bus.InstrAddr), 32'd0);
    chk("rs_done", 32'(bus.Done), 32'd0);
    chk("rs_cnt",  32'(bus.CycleCount), 32'd0);
    tick();
    bus.Start = 1'b0;
    chk("rs_start_ign", 32'(bus.InstrAddr), 32'd1);
    tick();
    chk("rs_addr2", 32'(bus.InstrAddr), 32'd2);
    tick();
    chk("f_addr3", 32'(bus.InstrAddr), 32'd3);
    chk("f_instr", 32'(bus.Instr), 32'd2);
    chk("f_opnd",  32'(bus.Operand), 32'h2B);
    chk("f_tsel",  32'(bus.TypeSelect), 32'd3);

    // Branch not taken, then taken back to 3, then taken to 0x120
    bus.Branch = 1'b1; bus.BranchTaken = 1'b0; bus.Target = 10'h120;
    tick();
    chk("br_nt", 32'(bus.InstrAddr), 32'd4);
    bus.BranchTaken = 1'b1; bus.Target = 10'h003;
    tick();
    chk("br_back", 32'(bus.InstrAddr), 32'd3);
    bus.Target = 10'h120;
    tick();
    chk("br_t", 32'(bus.InstrAddr), 32'h120);
    bus.Target = 10'h3FF;
    tick();
    chk("br_top", 32'(bus.InstrAddr), 32'h3FF);
    bus.Branch = 1'b0; bus.BranchTaken = 1'b0;

    // Wrap at top of address space
    tick();
    chk("wrap_addr",  32'(bus.InstrAddr), 32'd0);
    chk("wrap_valid", 32'(bus.Valid), 32'd1);
    rom[1] = HALT_INSTR;
    tick();
    chk("hb_addr", 32'(bus.InstrAddr), 32'd1);

    // HALT beats a taken branch
    bus.Branch = 1'b1; bus.BranchTaken = 1'b1; bus.Target = 10'h055;
    tick();
    chk("hb_done", 32'(bus.Done), 32'd1);
    chk("hb_hold", 32'(bus.InstrAddr), 32'd1);
    chk("hb_cnt",  32'(bus.CycleCount), cnt_exp(10));
    bus.Branch = 1'b0; bus.BranchTaken = 1'b0;

    // Async reset mid-run at PC 5
    rom[1] = 9'h000;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("mr_addr5", 32'(bus.InstrAddr), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("mr_addr",  32'(bus.InstrAddr), 32'd0);
    chk("mr_done",  32'(bus.Done), 32'd0);
    chk("mr_instr", 32'(bus.Instr), 32'd7);
    chk("mr_valid", 32'(bus.Valid), 32'd0);
    chk("mr_cnt",   32'(bus.CycleCount), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mr_idle_valid", 32'(bus.Valid), 32'd0);
    chk("mr_idle_done",  32'(bus.Done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
